// File: rtl/instr_fetch_unit.sv
// Fetch stage for KGP_RISC: owns the PC, issues in-order imem reads, and queues {inst, pc} for DataPath.
// Optional FETCH_PERF_EN adds saturating dequeue/redirect counters (perf_fetch_cnt, perf_flush_cnt).
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   r_fetch_pc;
    logic          r_run;
    logic [CW-1:0] r_q_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [AW-1:0] r_q_wptr;
    logic [AW-1:0] r_q_rptr;
    logic [AW-1:0] r_tag_wptr;
    logic [AW-1:0] r_tag_rptr;
    logic [31:0]   r_q_inst [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_tag_pc [DEPTH];

    logic          w_head_pop;
    logic          w_pop;
    logic          w_push;
    logic          w_rsp;
    logic          w_dropping;
    logic          w_req_fire;
    logic [CW:0]   w_credit_used;
    logic [CW-1:0] w_q_count_nxt;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_drop_nxt;

    // Credit counts queue entries plus in-flight requests; a same-cycle dequeue
    // frees its slot early so the stage sustains one instruction per cycle.
    always_comb begin
        w_head_pop     = inst_valid & inst_ready;
        w_credit_used  = {1'b0, r_q_count} + {1'b0, r_outstanding} - {{CW{1'b0}}, w_head_pop};
        imem_req_valid = r_run & ~redirect_valid & (w_credit_used < (CW+1)'(DEPTH));
        w_req_fire     = imem_req_valid & imem_req_ready;
        w_rsp          = imem_rsp_valid & (r_outstanding != '0);
        w_dropping     = (r_drop_cnt != '0);
        w_pop          = w_head_pop & ~redirect_valid;
        w_push         = w_rsp & ~w_dropping & ~redirect_valid;
    end

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_req_fire && !w_rsp) begin
            w_out_nxt = r_outstanding + CW'(1);
        end else if (!w_req_fire && w_rsp) begin
            w_out_nxt = r_outstanding - CW'(1);
        end

        w_drop_nxt = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_nxt = w_out_nxt;
        end else if (w_rsp && w_dropping) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
        end

        w_q_count_nxt = r_q_count;
        if (redirect_valid) begin
            w_q_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_q_count_nxt = r_q_count + CW'(1);
                2'b01:   w_q_count_nxt = r_q_count - CW'(1);
                default: w_q_count_nxt = r_q_count;
            endcase
        end
    end

    always_comb begin
        imem_addr  = r_fetch_pc;
        inst_valid = (r_q_count != '0);
        inst       = inst_valid ? r_q_inst[r_q_rptr] : '0;
        inst_pc    = inst_valid ? r_q_pc[r_q_rptr]   : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_run         <= 1'b0;
            r_q_count     <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_q_wptr      <= '0;
            r_q_rptr      <= '0;
            r_tag_wptr    <= '0;
            r_tag_rptr    <= '0;
        end else begin
            r_run         <= 1'b1;
            r_q_count     <= w_q_count_nxt;
            r_outstanding <= w_out_nxt;
            r_drop_cnt    <= w_drop_nxt;

            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_INC;
            end

            if (redirect_valid) begin
                r_q_wptr <= '0;
                r_q_rptr <= '0;
            end else begin
                if (w_push) r_q_wptr <= r_q_wptr + AW'(1);
                if (w_pop)  r_q_rptr <= r_q_rptr + AW'(1);
            end

            // Tags of dropped responses still retire, keeping tag order aligned with memory order.
            if (w_req_fire) r_tag_wptr <= r_tag_wptr + AW'(1);
            if (w_rsp)      r_tag_rptr <= r_tag_rptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_q_wptr] <= imem_rsp_data;
            r_q_pc[r_q_wptr]   <= r_tag_pc[r_tag_rptr];
        end
        if (w_req_fire) begin
            r_tag_pc[r_tag_wptr] <= r_fetch_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_pop && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, variable-latency instruction memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;

    int unsigned mem_lat   = 1;
    bit          mem_clear = 1'b1;
    int unsigned cyc       = 0;
    logic [31:0] mq_addr [$];
    int unsigned mq_due  [$];

    instr_fetch_unit #(
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory: accepts on req handshake, answers in order mem_lat cycles later with 0x1000_0000+addr.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!mem_clear && imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + mem_lat);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (mem_clear) begin
                mq_addr.delete();
                mq_due.delete();
                imem_rsp_valid = 1'b0;
            end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'h1000_0000 + mq_addr[0];
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b0;
        mem_clear      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        mem_lat        = 1;
        repeat (2) @(negedge clk);
        mem_clear = 1'b0;
        rst       = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b inst=%h pc=%h, required 0/0/0", inst_valid, inst, inst_pc);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_req: req_valid=%b addr=%h, required 0/00000000", imem_req_valid, imem_addr);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_perf: fetch=%0d flush=%0d, required 0/0", perf_fetch_cnt, perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_basic_fetch();
        logic [31:0] exp_pc;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_first_req: req_valid=%b addr=%h, required 1/00000000", imem_req_valid, imem_addr);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_bypass: inst_valid=%b, required 0", inst_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_pc = 32'(i * 4);
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== 32'h1000_0000 + exp_pc) begin
                n_fail++;
                $display("FAIL basic_seq%0d: valid=%b pc=%h inst=%h, required 1/%h/%h",
                         i, inst_valid, inst_pc, inst, exp_pc, 32'h1000_0000 + exp_pc);
            end
        end
    endtask

    task automatic test_backpressure();
        int          nfire;
        int          got;
        int          budget;
        logic [31:0] exp_pc;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        nfire          = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) nfire++;
        end
        n_checks++;
        if (nfire != 2) begin
            n_fail++;
            $display("FAIL bp_req_count: issued %0d, required 2", nfire);
        end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_hold_head: valid=%b pc=%h, required 1/00000000", inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        got        = 0;
        budget     = 8;
        while (got < 3 && budget > 0) begin
            if (inst_valid && inst_ready) begin
                exp_pc = 32'(got * 4);
                n_checks++;
                if (inst_pc !== exp_pc || inst !== 32'h1000_0000 + exp_pc) begin
                    n_fail++;
                    $display("FAIL bp_release%0d: pc=%h inst=%h, required %h/%h",
                             got, inst_pc, inst, exp_pc, 32'h1000_0000 + exp_pc);
                end
                got++;
            end
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL bp_release_count: delivered %0d, required 3", got);
        end
    endtask

    task automatic test_mem_stall();
        bit found;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        found          = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_addr == 32'h8) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL stall_reach8: request to 00000008 not seen, required within 6 cycles");
        end
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_hold%0d: req_valid=%b addr=%h, required 1/00000008", i, imem_req_valid, imem_addr);
            end
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_next: req_valid=%b addr=%h, required 1/0000000c", imem_req_valid, imem_addr);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'h1000_0008) begin
            n_fail++;
            $display("FAIL stall_deliver: valid=%b pc=%h inst=%h, required 1/00000008/10000008", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_redirect_inflight();
        int          got;
        int          budget;
        logic [31:0] exp_pc;
        do_reset();
        mem_lat        = 6;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_addr !== 32'h18) begin
            n_fail++;
            $display("FAIL inflight_credit: req_valid=%b addr=%h, required 0/00000018", imem_req_valid, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        got    = 0;
        budget = 40;
        while (got < 2 && budget > 0) begin
            if (inst_valid && inst_ready) begin
                exp_pc = 32'h100 + 32'(got * 4);
                n_checks++;
                if (inst_pc !== exp_pc || inst !== 32'h1000_0000 + exp_pc) begin
                    n_fail++;
                    $display("FAIL inflight_seq%0d: pc=%h inst=%h, required %h/%h",
                             got, inst_pc, inst, exp_pc, 32'h1000_0000 + exp_pc);
                end
                got++;
            end
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL inflight_count: delivered %0d, required 2", got);
        end
    endtask

    task automatic test_redirect_same_cycle();
        bit          found;
        int          got;
        int          budget;
        logic [31:0] exp_pc;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        found          = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (imem_rsp_valid && imem_rsp_data == 32'h1000_0008) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL samecyc_rsp8: response for 00000008 not seen, required within 8 cycles");
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL samecyc_no_req: req_valid=%b during redirect, required 0", imem_req_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL samecyc_after: inst_valid=%b req_valid=%b addr=%h, required 0/1/00000040",
                     inst_valid, imem_req_valid, imem_addr);
        end
        got    = 0;
        budget = 10;
        while (got < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (inst_valid && inst_ready) begin
                exp_pc = 32'h40 + 32'(got * 4);
                n_checks++;
                if (inst_pc !== exp_pc || inst !== 32'h1000_0000 + exp_pc) begin
                    n_fail++;
                    $display("FAIL samecyc_seq%0d: pc=%h inst=%h, required %h/%h",
                             got, inst_pc, inst, exp_pc, 32'h1000_0000 + exp_pc);
                end
                got++;
            end
        end
        n_checks++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL samecyc_count: delivered %0d, required 2", got);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_flush_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL samecyc_perf_flush: got %0d, required 1", perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int          got;
        int          budget;
        logic [31:0] exp_pc;
        do_reset();
        mem_lat        = 6;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        got    = 0;
        budget = 40;
        while (got < 2 && budget > 0) begin
            if (inst_valid && inst_ready) begin
                exp_pc = 32'h300 + 32'(got * 4);
                n_checks++;
                if (inst_pc !== exp_pc || inst !== 32'h1000_0000 + exp_pc) begin
                    n_fail++;
                    $display("FAIL b2b_seq%0d: pc=%h inst=%h, required %h/%h",
                             got, inst_pc, inst, exp_pc, 32'h1000_0000 + exp_pc);
                end
                got++;
            end
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL b2b_count: delivered %0d, required 2", got);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_flush_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_perf_flush: got %0d, required 2", perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_pc_wrap();
        int          got;
        int          budget;
        logic [31:0] exp_pc;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        got    = 0;
        budget = 12;
        while (got < 4 && budget > 0) begin
            if (inst_valid && inst_ready) begin
                exp_pc = 32'hFFFF_FFF8 + 32'(got * 4);
                n_checks++;
                if (inst_pc !== exp_pc || inst !== 32'h1000_0000 + exp_pc) begin
                    n_fail++;
                    $display("FAIL wrap_seq%0d: pc=%h inst=%h, required %h/%h",
                             got, inst_pc, inst, exp_pc, 32'h1000_0000 + exp_pc);
                end
                got++;
            end
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL wrap_count: delivered %0d, required 4", got);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_pre: valid=%b pc=%h, required 1/00000000", inst_valid, inst_pc);
        end
        #2;
        rst       = 1'b0;
        mem_clear = 1'b1;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_outputs: valid=%b inst=%h pc=%h, required 0/0/0", inst_valid, inst, inst_pc);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_req: req_valid=%b addr=%h, required 0/00000000", imem_req_valid, imem_addr);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_perf: fetch=%0d flush=%0d, required 0/0", perf_fetch_cnt, perf_flush_cnt);
        end
`endif
        repeat (2) @(negedge clk);
        mem_clear  = 1'b0;
        rst        = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_restart_req: req_valid=%b addr=%h, required 1/00000000", imem_req_valid, imem_addr);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL areset_restart_inst: valid=%b pc=%h inst=%h, required 1/00000000/10000000",
                     inst_valid, inst_pc, inst);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_mem_stall();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_back_to_back();
        test_pc_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of DataPath in KGP_RISC.
- Owns the architectural PC and issues sequential instruction-memory reads.
- Buffers returned instructions in a small in-order queue and presents {instruction, pc} to DataPath through a valid/ready handshake.
- Redirects, i.e. a taken branch or jump resolved by DataPath as pc_next, flush the queue and discard in-flight responses.

Parameters:
- DEPTH, 2: instruction queue entries; also the maximum number of outstanding memory requests. Power of 2, ≥2.
- RESET_PC, 32'h0000_0000: PC value loaded at reset.
- PC_INC, 4: sequential PC increment per fetched instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  fetch address; equals fetch_pc.
- imem_rsp_valid  in  1  response data valid. Responses are in order, latency ≥1 cycle.
- imem_rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  DataPath requests a PC change.
- redirect_pc  in  32  new PC (DataPath pc_next).
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  DataPath consumes the head this cycle.
- inst  out  32  head instruction.
- inst_pc  out  32  PC of the head instruction.

Behaviour:
- **Reset** (rst=0, asynchronous):
  - fetch_pc=RESET_PC.
  - Queue empty, so inst_valid=0; inst and inst_pc read 0.
  - Outstanding count=0, drop count=0, imem_req_valid=0.
  - First request may assert the cycle after rst deasserts.
- **Request issue:**
  - imem_req_valid=1 when (queue_count + outstanding) < DEPTH and redirect_valid=0.
  - On imem_req_valid & imem_req_ready: fetch_pc += PC_INC (32-bit wrap, 32'hFFFF_FFFC+4 → 0) and outstanding++.
  - The tag PC of each request is pushed into an internal PC FIFO (DEPTH entries) so responses pair with their PC.
  - imem_addr must stay stable while imem_req_valid=1 and imem_req_ready=0.
- **Response:**
  - On imem_rsp_valid: outstanding--.
  - If drop count>0: drop count-- and the data is discarded.
  - Otherwise {imem_rsp_data, tag PC} is written to the queue tail.
  - The queue is never full when a non-dropped response arrives; credit accounting guarantees this.
- **Dequeue:**
  - On inst_valid & inst_ready the head pops.
  - Push and pop in the same cycle are allowed, including on a full queue.
  - An empty-queue response is visible at the outputs the following cycle (registered queue, no bypass).
- **Redirect** (redirect_valid=1, highest priority):
  - Queue is flushed; inst_valid=0 next cycle. A same-cycle pop is ignored.
  - fetch_pc=redirect_pc.
  - drop count = outstanding after this cycle's request and response updates. A response arriving in the redirect cycle is dropped, not enqueued.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop counts accumulate correctly.
- **Latency:** redirect → first new imem_req_valid takes 1 cycle. Response → inst_valid takes 1 cycle.
- **Mid-operation reset:** all state clears immediately; outstanding memory responses after reset are the memory's responsibility.

Optional Feature:
- Macro: FETCH_PERF_EN.
- **Defined:** adds output port perf_fetch_cnt (out, 32) and output port perf_flush_cnt (out, 32).
  - perf_fetch_cnt increments on every dequeue handshake.
  - perf_flush_cnt increments once per redirect cycle.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- **Undefined:** neither port nor counter exists; all other behaviour is identical.

Test Plan:
- **Basic fetch:** reset, then imem_req_ready=1, memory returns 32'h1000_0000+addr with 1-cycle latency, inst_ready=1 → inst_pc sequence 0,4,8,12 and inst = 32'h1000_0000,32'h1000_0004,..., one per cycle after fill.
- **Backpressure:** inst_ready=0 for 10 cycles → exactly DEPTH=2 requests issued, inst_valid=1 holding pc 0. Release → pcs 0,4,8 delivered in order with no loss or duplicate.
- **Memory stall:** imem_req_ready=0 for 5 cycles at fetch_pc=8 → imem_addr holds 8, no PC advance. Ready=1 → request to 8, then 12.
- **Redirect with in-flight:** 2 requests (pcs 16,20) outstanding, redirect_valid=1 with redirect_pc=32'h0000_0100 → both responses discarded, next inst_pc=32'h100, then 32'h104.
- **Redirect + response same cycle:** response for pc 8 coincides with redirect to 32'h40 → pc 8 never appears on inst; first inst_pc=32'h40.
- **Async reset mid-fetch:** rst=0 asynchronously with queue full → inst_valid=0 before the next clk edge. After release, fetch restarts at RESET_PC=0. With FETCH_PERF_EN defined, both perf counters read 0.
